// File: rtl/nlm_weight_accum_pkg.sv
// Shared NLM constants, FSM encoding and the saturating clamp used by the
// accumulation and output control stages.
package nlm_weight_accum_pkg;

    localparam int NLM_DATA_WIDTH   = 12;
    localparam int NLM_SUM_WIDTH    = 26;
    localparam int NLM_WEIGHT_WIDTH = 8;
    localparam int NLM_WIN_RADIUS   = 6;

    // Search-window candidates, centre pixel excluded.
    function automatic int num_cand(input int radius);
        return (2 * radius + 1) * (2 * radius + 1) - 1;
    endfunction

    localparam int NLM_NUM_CAND = num_cand(NLM_WIN_RADIUS);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACC  = 1'b1
    } nlm_state_e;

    function automatic logic [63:0] sat_clamp(input logic [63:0] val, input int out_w);
        logic [63:0] max_v;
        max_v = (64'd1 << out_w) - 64'd1;
        return (val > max_v) ? max_v : val;
    endfunction

endpackage

// File: rtl/nlm_weight_accum_sat_acc.sv
// Loadable accumulator with two guard bits; the registered output is the
// saturated total captured on the close beat of a group.
module nlm_sat_acc
    import nlm_weight_accum_pkg::*;
#(
    parameter int IN_W  = 20,
    parameter int OUT_W = 26
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             load_i,
    input  logic             close_i,
    input  logic [IN_W-1:0]  data_i,
    output logic [OUT_W-1:0] sum_o
);

    localparam int ACC_W = OUT_W + 2;

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic [OUT_W-1:0] sum_q;
    logic [OUT_W-1:0] sat_d;

    // A first beat restarts the sum, so a new group can follow a close directly.
    always_comb begin
        acc_d = load_i ? ACC_W'(data_i) : acc_q + ACC_W'(data_i);
        sat_d = OUT_W'(sat_clamp(64'(acc_d), OUT_W));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            sum_q <= '0;
        end else if (en_i) begin
            acc_q <= acc_d;
            if (close_i) begin
                sum_q <= sat_d;
            end
        end
    end

    assign sum_o = sum_q;

endmodule

// File: rtl/nlm_weight_accum.sv
// NLM accumulation stage: sums weight*pixel and weight over each centre
// pixel's candidate stream and emits one aligned result beat per group.
module nlm_weight_accum
    import nlm_weight_accum_pkg::*;
#(
    parameter int SUM_WIDTH    = NLM_SUM_WIDTH,
    parameter int DATA_WIDTH   = NLM_DATA_WIDTH,
    parameter int WEIGHT_WIDTH = NLM_WEIGHT_WIDTH,
    parameter int WIN_RADIUS   = NLM_WIN_RADIUS
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            cand_valid_i,
    input  logic [WEIGHT_WIDTH-1:0]         cand_weight_i,
    input  logic [DATA_WIDTH-1:0]           cand_pix_i,
    input  logic                            cand_last_i,
    input  logic [DATA_WIDTH-1:0]           center_pix_i,
    output logic                            valid_o,
    output logic [SUM_WIDTH-1:0]            pix_sum_o,
    output logic [SUM_WIDTH-DATA_WIDTH-1:0] weight_sum_o,
    output logic [DATA_WIDTH-1:0]           pix_o,
    output logic                            cnt_err_o
);

    localparam int NUM_CAND = num_cand(WIN_RADIUS);
    localparam int CNT_W    = $clog2(NUM_CAND + 1);
    localparam int PROD_W   = WEIGHT_WIDTH + DATA_WIDTH;
    localparam int WSUM_W   = SUM_WIDTH - DATA_WIDTH;

    // Handshake: cand_valid_i alone qualifies a beat. There is no ready, so
    // every valid beat is consumed in the cycle it is presented.
    nlm_state_e              state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [CNT_W-1:0]        cnt_d;
    logic                    first_d;
    logic                    close_d;
    logic                    err_d;
    logic [DATA_WIDTH-1:0]   center_q;
    logic                    cnt_err_q;

    logic                    p_valid_q;
    logic                    p_first_q;
    logic                    p_close_q;
    logic [PROD_W-1:0]       p_prod_q;
    logic [WEIGHT_WIDTH-1:0] p_weight_q;

    logic                    valid_q;
    logic [DATA_WIDTH-1:0]   pix_q;

    always_comb begin
        first_d = (state_q == ST_IDLE);
        cnt_d   = first_d ? CNT_W'(1) : cnt_q + CNT_W'(1);
        close_d = cand_last_i || (cnt_d == CNT_W'(NUM_CAND));
        // Wrong-length last, or a full group that never saw its last flag.
        err_d   = cand_valid_i &&
                  (cand_last_i ? (cnt_d != CNT_W'(NUM_CAND)) : (cnt_d == CNT_W'(NUM_CAND)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            center_q   <= '0;
            cnt_err_q  <= 1'b0;
            p_valid_q  <= 1'b0;
            p_first_q  <= 1'b0;
            p_close_q  <= 1'b0;
            p_prod_q   <= '0;
            p_weight_q <= '0;
        end else begin
            p_valid_q  <= cand_valid_i;
            p_first_q  <= first_d;
            p_close_q  <= close_d;
            p_prod_q   <= PROD_W'(cand_weight_i) * PROD_W'(cand_pix_i);
            p_weight_q <= cand_weight_i;
            if (cand_valid_i) begin
                if (first_d) begin
                    center_q <= center_pix_i;
                end
                state_q <= close_d ? ST_IDLE : ST_ACC;
                cnt_q   <= close_d ? '0 : cnt_d;
            end
            if (err_d) begin
                cnt_err_q <= 1'b1;
            end
        end
    end

    nlm_sat_acc #(.IN_W(PROD_W), .OUT_W(SUM_WIDTH)) u_pix_acc (
        .clk     (clk),
        .rst     (rst),
        .en_i    (p_valid_q),
        .load_i  (p_first_q),
        .close_i (p_close_q),
        .data_i  (p_prod_q),
        .sum_o   (pix_sum_o)
    );

    nlm_sat_acc #(.IN_W(WEIGHT_WIDTH), .OUT_W(WSUM_W)) u_wgt_acc (
        .clk     (clk),
        .rst     (rst),
        .en_i    (p_valid_q),
        .load_i  (p_first_q),
        .close_i (p_close_q),
        .data_i  (p_weight_q),
        .sum_o   (weight_sum_o)
    );

    // center_q still holds this group's pixel here even if the next group
    // opened on the same edge, because that update lands after this read.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            pix_q   <= '0;
        end else begin
            valid_q <= p_valid_q && p_close_q;
            if (p_valid_q && p_close_q) begin
                pix_q <= center_q;
            end
        end
    end

    assign valid_o   = valid_q;
    assign pix_o     = pix_q;
    assign cnt_err_o = cnt_err_q;

endmodule

// File: tb/tb_nlm_weight_accum.sv
// Bench for nlm_weight_accum: constant-pattern vector table, hand-built
// corner sequences and a randomized stream against a group-level model.
module tb_nlm_weight_accum;
    import nlm_weight_accum_pkg::*;

    localparam int SW  = 26;
    localparam int DW  = 12;
    localparam int WW  = 8;
    localparam int NWS = SW - DW;
    localparam int NC  = 168;
    localparam longint PS_MAX = (64'd1 << SW) - 1;
    localparam longint WS_MAX = (64'd1 << NWS) - 1;

    logic           clk;
    logic           rst;
    logic           cand_valid_i;
    logic [WW-1:0]  cand_weight_i;
    logic [DW-1:0]  cand_pix_i;
    logic           cand_last_i;
    logic [DW-1:0]  center_pix_i;
    logic           valid_o;
    logic [SW-1:0]  pix_sum_o;
    logic [NWS-1:0] weight_sum_o;
    logic [DW-1:0]  pix_o;
    logic           cnt_err_o;

    nlm_weight_accum dut (
        .clk           (clk),
        .rst           (rst),
        .cand_valid_i  (cand_valid_i),
        .cand_weight_i (cand_weight_i),
        .cand_pix_i    (cand_pix_i),
        .cand_last_i   (cand_last_i),
        .center_pix_i  (center_pix_i),
        .valid_o       (valid_o),
        .pix_sum_o     (pix_sum_o),
        .weight_sum_o  (weight_sum_o),
        .pix_o         (pix_o),
        .cnt_err_o     (cnt_err_o)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        longint psum;
        longint wsum;
        longint pix;
        int     cycle;
    } res_t;

    res_t exp_q[$];
    res_t res_log[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Group-level reference: beats are tallied until a last flag or the
    // full candidate count; the result is due two edges after the close beat.
    bit          m_open;
    int          m_cnt;
    longint      m_ps;
    longint      m_ws;
    longint      m_c;
    bit          m_err;

    function automatic longint clamp(input longint v, input longint mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_reset();
        m_open = 0;
        m_cnt  = 0;
        m_ps   = 0;
        m_ws   = 0;
        m_c    = 0;
        m_err  = 0;
        exp_q.delete();
        res_log.delete();
    endtask

    task automatic model_beat(input int w, input int p, input bit last, input int c, input int due);
        res_t r;
        if (!m_open) begin
            m_open = 1;
            m_cnt  = 0;
            m_ps   = 0;
            m_ws   = 0;
            m_c    = c;
        end
        m_cnt++;
        m_ps += longint'(w) * longint'(p);
        m_ws += w;
        if (last || m_cnt == NC) begin
            if (m_cnt != NC || !last) m_err = 1;
            r.psum  = clamp(m_ps, PS_MAX);
            r.wsum  = clamp(m_ws, WS_MAX);
            r.pix   = m_c;
            r.cycle = due;
            exp_q.push_back(r);
            m_open = 0;
        end
    endtask

    always @(negedge clk) begin
        res_t e;
        res_t g;
        if (!rst && valid_o) begin
            g.psum  = pix_sum_o;
            g.wsum  = weight_sum_o;
            g.pix   = pix_o;
            g.cycle = cyc;
            res_log.push_back(g);
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("res_pix_sum", g.psum, e.psum);
                check("res_weight_sum", g.wsum, e.wsum);
                check("res_pix", g.pix, e.pix);
                check("res_latency_cycle", g.cycle, e.cycle);
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic drive_beat(input int w, input int p, input bit last, input int c);
        cand_valid_i  = 1'b1;
        cand_weight_i = w[WW-1:0];
        cand_pix_i    = p[DW-1:0];
        cand_last_i   = last;
        center_pix_i  = c[DW-1:0];
        model_beat(w, p, last, c, cyc + 2);
        @(negedge clk);
        cand_valid_i  = 1'b0;
        cand_last_i   = 1'b0;
    endtask

    task automatic idle(input int n);
        cand_valid_i = 1'b0;
        cand_last_i  = 1'b0;
        cand_weight_i = WW'($urandom_range(0, 255));
        repeat (n) @(negedge clk);
    endtask

    // Beats with random gaps inside; last_at = 0 means never flag last.
    task automatic drive_group(input int w, input int p, input int c, input int beats, input int last_at);
        for (int b = 1; b <= beats; b++) begin
            drive_beat(w, p, b == last_at, c);
            if (b < beats && $urandom_range(0, 4) == 0) idle($urandom_range(1, 2));
        end
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        cand_valid_i = 1'b0;
        cand_last_i  = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_valid", valid_o, 0);
        check("rst_pix_sum", pix_sum_o, 0);
        check("rst_weight_sum", weight_sum_o, 0);
        check("rst_pix", pix_o, 0);
        check("rst_cnt_err", cnt_err_o, 0);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int     w;
        int     p;
        int     c;
        int     beats;
        int     last_at;
        longint ps;
        longint ws;
        int     pix;
        bit     err;
    } vec_t;

    vec_t tbl[5];

    initial begin
        int w;
        int len;
        rst           = 1'b1;
        cand_valid_i  = 1'b0;
        cand_weight_i = '0;
        cand_pix_i    = '0;
        cand_last_i   = 1'b0;
        center_pix_i  = '0;
        model_reset();

        tbl[0] = '{w: 1,   p: 100,  c: 50,   beats: 168, last_at: 168, ps: 16800,    ws: 168,   pix: 50,   err: 0};
        tbl[1] = '{w: 255, p: 4095, c: 4095, beats: 168, last_at: 168, ps: 67108863, ws: 16383, pix: 4095, err: 0};
        tbl[2] = '{w: 1,   p: 7,    c: 9,    beats: 5,   last_at: 5,   ps: 35,       ws: 5,     pix: 9,    err: 1};
        tbl[3] = '{w: 5,   p: 11,   c: 3,    beats: 1,   last_at: 1,   ps: 55,       ws: 5,     pix: 3,    err: 1};
        tbl[4] = '{w: 1,   p: 1,    c: 77,   beats: 170, last_at: 0,   ps: 168,      ws: 168,   pix: 77,   err: 1};

        repeat (2) @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            do_reset();
            drive_group(tbl[i].w, tbl[i].p, tbl[i].c, tbl[i].beats, tbl[i].last_at);
            idle(4);
            check("tbl_result_count", res_log.size(), 1);
            if (res_log.size() == 1) begin
                check("tbl_pix_sum", res_log[0].psum, tbl[i].ps);
                check("tbl_weight_sum", res_log[0].wsum, tbl[i].ws);
                check("tbl_pix", res_log[0].pix, tbl[i].pix);
            end
            check("tbl_cnt_err", cnt_err_o, tbl[i].err);
            check("tbl_exp_drained", exp_q.size(), 0);
        end

        // Back-to-back groups, no gap between them, gaps inside each.
        do_reset();
        drive_group(2, 10, 111, 168, 168);
        drive_group(3, 20, 222, 168, 168);
        idle(4);
        check("b2b_result_count", res_log.size(), 2);
        if (res_log.size() == 2) begin
            check("b2b_a_pix_sum", res_log[0].psum, 3360);
            check("b2b_a_weight_sum", res_log[0].wsum, 336);
            check("b2b_a_pix", res_log[0].pix, 111);
            check("b2b_b_pix_sum", res_log[1].psum, 10080);
            check("b2b_b_weight_sum", res_log[1].wsum, 504);
            check("b2b_b_pix", res_log[1].pix, 222);
        end
        check("b2b_cnt_err", cnt_err_o, 0);

        // Sticky error survives a later clean group; reset mid-group discards.
        do_reset();
        drive_group(1, 7, 5, 5, 5);
        drive_group(1, 100, 50, 168, 168);
        idle(4);
        check("sticky_result_count", res_log.size(), 2);
        check("sticky_cnt_err", cnt_err_o, 1);
        drive_group(9, 9, 9, 80, 0);
        do_reset();
        drive_group(4, 9, 12, 168, 168);
        idle(4);
        check("midrst_result_count", res_log.size(), 1);
        if (res_log.size() == 1) begin
            check("midrst_pix_sum", res_log[0].psum, 6048);
            check("midrst_weight_sum", res_log[0].wsum, 672);
            check("midrst_pix", res_log[0].pix, 12);
        end
        check("midrst_cnt_err", cnt_err_o, 0);

        // Randomized stream: lengths, weights, pixels, centres, gaps, missing lasts.
        do_reset();
        for (int g = 0; g < 30; g++) begin
            len = $urandom_range(1, 168);
            for (int b = 1; b <= len; b++) begin
                w = (g % 4 == 0) ? 255 : int'($urandom_range(0, 255));
                drive_beat(w, $urandom_range(0, 4095),
                           (b == len) && ($urandom_range(0, 7) != 0),
                           $urandom_range(0, 4095));
                if ($urandom_range(0, 9) == 0) idle($urandom_range(1, 3));
            end
        end
        idle(4);
        check("rand_exp_drained", exp_q.size(), 0);
        check("rand_cnt_err", cnt_err_o, m_err);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
